// File: rtl/candy_wb_pkg.sv
// Shared widths, reset levels and write-back target encoding for the candy
// write-back stage.
package candy_wb_pkg;

  localparam int unsigned SRAMDataWidth = 24;
  localparam int unsigned SRAMAddrWidth = 17;
  localparam int unsigned RegAddrBus    = 4;
  localparam int unsigned RegBus        = 24;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  // Destination of an accepted write-back request.
  typedef enum logic [1:0] {
    WB_TGT_NONE = 2'b00,
    WB_TGT_REG  = 2'b01,
    WB_TGT_SRAM = 2'b10
  } wb_target_e;

  // Resolve the destination from the request qualifiers. is_mem is only
  // consulted when the request is valid, so an unknown is_mem on an idle
  // cycle cannot leak into either write strobe.
  function automatic wb_target_e wb_target(input logic enable, input logic is_mem);
    wb_target_e tgt;
    tgt = WB_TGT_NONE;
    if (enable == 1'b1) begin
      if (is_mem == 1'b1) begin
        tgt = WB_TGT_SRAM;
      end else begin
        tgt = WB_TGT_REG;
      end
    end
    return tgt;
  endfunction

endpackage

// File: rtl/candy_wb_port.sv
// Registered write port: a one-cycle write strobe plus address/data that are
// captured only on an accepted request and otherwise hold.
module candy_wb_port
  import candy_wb_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // Strobe follows the request every cycle; address/data load on request, hold otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst == RstEnable) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= i_req;
      if (i_req) begin
        r_addr <= i_addr;
        r_data <= i_data;
      end
    end
  end

  assign o_we   = r_we;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/candy_wb.sv
// Write-back stage: commits the final result either to the data SRAM (memory
// ops) or to the register file, with all outputs registered (1-cycle latency).
module candy_wb
  import candy_wb_pkg::*;
#(
  parameter int unsigned DATA_W      = SRAMDataWidth,
  parameter int unsigned SRAM_ADDR_W = SRAMAddrWidth,
  parameter int unsigned REG_ADDR_W  = RegAddrBus,
  parameter int unsigned REG_W       = RegBus
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   is_mem,
  input  logic                   wb_enable,
  input  logic [DATA_W-1:0]      result,
  input  logic [SRAM_ADDR_W-1:0] sram_result_addr,
  input  logic [REG_ADDR_W-1:0]  reg_addr,
  output logic                   sram_write_enable,
  output logic [DATA_W-1:0]      sram_wdata,
  output logic [SRAM_ADDR_W-1:0] sram_waddr,
  output logic                   reg_write_enable,
  output logic [REG_ADDR_W-1:0]  reg_waddr,
  output logic [REG_W-1:0]       reg_wdata
);

  wb_target_e       w_target;
  logic             w_sram_req;
  logic             w_reg_req;
  logic [REG_W-1:0] w_reg_data;

  // Decode the request into exactly one (or no) destination; the two
  // requests are one-hot by construction, so the enables can never overlap.
  always_comb begin
    w_target   = wb_target(wb_enable, is_mem);
    w_sram_req = 1'b0;
    w_reg_req  = 1'b0;
    unique case (w_target)
      WB_TGT_SRAM: w_sram_req = 1'b1;
      WB_TGT_REG:  w_reg_req  = 1'b1;
      default: begin
        w_sram_req = 1'b0;
        w_reg_req  = 1'b0;
      end
    endcase
  end

  assign w_reg_data = result;

  candy_wb_port #(
    .DATA_W (DATA_W),
    .ADDR_W (SRAM_ADDR_W)
  ) u_sram_port (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_req  (w_sram_req),
    .i_addr (sram_result_addr),
    .i_data (result),
    .o_we   (sram_write_enable),
    .o_addr (sram_waddr),
    .o_data (sram_wdata)
  );

  candy_wb_port #(
    .DATA_W (REG_W),
    .ADDR_W (REG_ADDR_W)
  ) u_reg_port (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_req  (w_reg_req),
    .i_addr (reg_addr),
    .i_data (w_reg_data),
    .o_we   (reg_write_enable),
    .o_addr (reg_waddr),
    .o_data (reg_wdata)
  );

endmodule

// File: tb/tb_candy_wb.sv
// Directed self-checking bench for the candy write-back stage.
module tb_candy_wb;

  logic        clk;
  logic        rst;
  logic        is_mem;
  logic        wb_enable;
  logic [23:0] result;
  logic [16:0] sram_result_addr;
  logic [3:0]  reg_addr;
  logic        sram_write_enable;
  logic [23:0] sram_wdata;
  logic [16:0] sram_waddr;
  logic        reg_write_enable;
  logic [3:0]  reg_waddr;
  logic [23:0] reg_wdata;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  candy_wb #(
    .DATA_W      (24),
    .SRAM_ADDR_W (17),
    .REG_ADDR_W  (4),
    .REG_W       (24)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .is_mem            (is_mem),
    .wb_enable         (wb_enable),
    .result            (result),
    .sram_result_addr  (sram_result_addr),
    .reg_addr          (reg_addr),
    .sram_write_enable (sram_write_enable),
    .sram_wdata        (sram_wdata),
    .sram_waddr        (sram_waddr),
    .reg_write_enable  (reg_write_enable),
    .reg_waddr         (reg_waddr),
    .reg_wdata         (reg_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag,
                           input logic s_we, input logic [23:0] s_d, input logic [16:0] s_a,
                           input logic r_we, input logic [3:0] r_a, input logic [23:0] r_d);
    check_eq({tag, ".sram_we"},   {31'd0, sram_write_enable}, {31'd0, s_we});
    check_eq({tag, ".sram_wdata"}, {8'd0, sram_wdata},        {8'd0, s_d});
    check_eq({tag, ".sram_waddr"}, {15'd0, sram_waddr},       {15'd0, s_a});
    check_eq({tag, ".reg_we"},    {31'd0, reg_write_enable},  {31'd0, r_we});
    check_eq({tag, ".reg_waddr"}, {28'd0, reg_waddr},         {28'd0, r_a});
    check_eq({tag, ".reg_wdata"}, {8'd0, reg_wdata},          {8'd0, r_d});
    check_eq({tag, ".exclusive"}, {31'd0, sram_write_enable & reg_write_enable}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; wb_enable = 1'b0; is_mem = 1'b0;
    result = '0; sram_result_addr = '0; reg_addr = '0;

    // 1. Reset, then idle after release
    step();
    check_all("reset", 1'b0, 24'h0, 17'd0, 1'b0, 4'h0, 24'h0);
    rst = 1'b0;
    step();
    check_all("idle", 1'b0, 24'h0, 17'd0, 1'b0, 4'h0, 24'h0);

    // 2. SRAM write
    wb_enable = 1'b1; is_mem = 1'b1; result = 24'h37c549;
    sram_result_addr = 17'd11; reg_addr = 4'h9;
    step();
    check_all("sram_wr", 1'b1, 24'h37c549, 17'd11, 1'b0, 4'h0, 24'h0);

    // 3. Regfile write; SRAM path holds
    is_mem = 1'b0; reg_addr = 4'h4; sram_result_addr = 17'h1ffff;
    step();
    check_all("reg_wr", 1'b0, 24'h37c549, 17'd11, 1'b1, 4'h4, 24'h37c549);

    // 4. Disable with unknown qualifiers: enables drop, data holds
    wb_enable = 1'b0; is_mem = 1'bx; sram_result_addr = 'x; reg_addr = 'x; result = 24'h123456;
    step();
    check_all("disable", 1'b0, 24'h37c549, 17'd11, 1'b0, 4'h4, 24'h37c549);

    // Held request: N cycles produce N write cycles with same data
    wb_enable = 1'b1; is_mem = 1'b1; result = 24'habcdef; sram_result_addr = 17'd100; reg_addr = 4'h1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("held", 1'b1, 24'habcdef, 17'd100, 1'b0, 4'h4, 24'h37c549);
    end

    // 5. Reset priority over a valid request
    rst = 1'b1; result = 24'hffffff;
    step();
    check_all("rst_prio", 1'b0, 24'h0, 17'd0, 1'b0, 4'h0, 24'h0);
    rst = 1'b0;

    // 6. Back-to-back alternation
    is_mem = 1'b1; result = 24'd1; sram_result_addr = 17'd20; reg_addr = 4'h3;
    step();
    check_all("alt1", 1'b1, 24'd1, 17'd20, 1'b0, 4'h0, 24'h0);
    is_mem = 1'b0; result = 24'd2; sram_result_addr = 17'd99; reg_addr = 4'h7;
    step();
    check_all("alt2", 1'b0, 24'd1, 17'd20, 1'b1, 4'h7, 24'd2);
    is_mem = 1'b1; result = 24'd3; sram_result_addr = 17'd21; reg_addr = 4'hc;
    step();
    check_all("alt3", 1'b1, 24'd3, 17'd21, 1'b0, 4'h7, 24'd2);
    is_mem = 1'b0; result = 24'd4; sram_result_addr = 17'd5; reg_addr = 4'h8;
    step();
    check_all("alt4", 1'b0, 24'd3, 17'd21, 1'b1, 4'h8, 24'd4);

    // Mid-stream reset drops the pending write
    is_mem = 1'b0; result = 24'd5; reg_addr = 4'h2; rst = 1'b1;
    step();
    check_all("mid_rst", 1'b0, 24'h0, 17'd0, 1'b0, 4'h0, 24'h0);
    rst = 1'b0; wb_enable = 1'b0;
    step();
    check_all("post_rst", 1'b0, 24'h0, 17'd0, 1'b0, 4'h0, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/candy_wb.md
Name: candy_wb

Overview:
Write-back stage of the candy CPU pipeline. It takes the final 24-bit result from the execute/memory stage and commits it to one of two places. If the instruction is a memory op, the result goes to the data SRAM. Otherwise it goes to the register file. All outputs are registered, so the block presents one-cycle-delayed write strobes to the SRAM and regfile.

Parameters:
DATA_W, 24, SRAM data width and result width (`SRAMDataWidth).
SRAM_ADDR_W, 17, SRAM address width (`SRAMAddrWidth).
REG_ADDR_W, 4, register-file address width (`RegAddrBus); 16 registers.
REG_W, 24, register data width (`RegBus); must equal DATA_W.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset (`RstEnable = 1'b1).
is_mem  input  1  1 = result targets SRAM; 0 = result targets register file.
wb_enable  input  1  write-back request valid this cycle.
result  input  DATA_W  value to write back.
sram_result_addr  input  SRAM_ADDR_W  SRAM target address (used when is_mem=1).
reg_addr  input  REG_ADDR_W  register target index (used when is_mem=0).
sram_write_enable  output  1  registered SRAM write strobe.
sram_wdata  output  DATA_W  registered SRAM write data.
sram_waddr  output  SRAM_ADDR_W  registered SRAM write address.
reg_write_enable  output  1  registered regfile write strobe.
reg_waddr  output  REG_ADDR_W  registered regfile write index.
reg_wdata  output  REG_W  registered regfile write data.

Behaviour:
- All outputs are flops updated on posedge clk. Latency is 1 cycle from input sample to output.
- Reset (rst=1 at a posedge):
  - all six outputs clear to 0;
  - rst has priority over wb_enable.
- wb_enable=1, is_mem=1:
  - sram_write_enable<=1, sram_wdata<=result, sram_waddr<=sram_result_addr;
  - reg_write_enable<=0; reg_waddr/reg_wdata hold.
- wb_enable=1, is_mem=0:
  - reg_write_enable<=1, reg_wdata<=result, reg_waddr<=reg_addr;
  - sram_write_enable<=0; sram_waddr/sram_wdata hold.
- wb_enable=0: both write enables <=0; all data/address outputs hold their last values.
- The two enables are mutually exclusive; never both 1 in the same cycle.
- Enables are single-cycle pulses per accepted request. A request held high for N cycles produces N consecutive write cycles with the same data; no edge detection.
- No back-pressure and no handshake: SRAM and regfile accept writes unconditionally.
- When wb_enable=0, is_mem and the unused address input are don't-care. X on them must not propagate to the enables.
- Reset asserted mid-stream drops any pending write: the next cycle shows both enables at 0.

Decomposition:
- Width macros (`SRAMDataWidth, `SRAMAddrWidth, `RegAddrBus, `RegBus) and `RstEnable/`RstDisable live in the shared candy_defines include/package. The block uses them for its parameter defaults.
- No sub-module is needed. Optionally factor a generic "enable+data register with hold" cell (candy_wb_port) instantiated twice, once for the SRAM path and once for the regfile path.

Test Plan:
1. Reset: rst=1, wb_enable=0 for 1 cycle -> all outputs 0 after the edge. Release rst; outputs stay 0 while wb_enable=0.
2. SRAM write: wb_enable=1, is_mem=1, result=24'h37c549, sram_result_addr=17'd11 -> next edge:
   - sram_write_enable=1, sram_wdata=24'h37c549, sram_waddr=11;
   - reg_write_enable=0.
3. Regfile write: wb_enable=1, is_mem=0, result=24'h37c549, reg_addr=4'h4 -> next edge:
   - reg_write_enable=1, reg_waddr=4, reg_wdata=24'h37c549;
   - sram_write_enable=0, sram_waddr stays 11.
4. Disable: after case 3, wb_enable=0 -> both enables 0 next edge; reg_waddr=4 and reg_wdata=24'h37c549 held.
5. Reset priority: rst=1 together with wb_enable=1, is_mem=1, result=24'hFFFFFF -> all outputs 0 next edge.
6. Back-to-back alternation over 4 cycles:
   - is_mem toggles 1,0,1,0, result=1,2,3,4;
   - enables alternate each cycle, never both high;
   - the data on each path matches the result of the cycle that targeted it.
